upload_packer_mc: RTL

Multi-channel, parametrised upload packer. It arbitrates round-robin among NUM_CH raw byte producers (handlers), buffers one payload of up to MAX_LEN bytes, and emits a framed packet `[HDR_H][HDR_L][source][len_hi][len_lo][payload…][checksum]` with a 16-bit length. It sits between the handler layer and the single upload stream toward the USB/UART transmitter. Backpressure is honoured byte by byte, and the frame streams with zero bubbles.

---
 rtl/upload_packer_mc_pkg.sv | 45 ++++
 rtl/upload_packer_mc_if.sv | 37 +++
 rtl/upload_packer_mc_rr_arbiter.sv | 39 +++
 rtl/upload_packer_mc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/upload_packer_mc_pkg.sv
`default_nettype none
// ============================================================================
// upload_pkg : shared states, constants and width helpers for the upload packer
// Revision   : 1.0
// ============================================================================
package upload_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_COLLECT = 4'd1,
    ST_HDR1    = 4'd2,
    ST_HDR2    = 4'd3,
    ST_SRC     = 4'd4,
    ST_LEN_H   = 4'd5,
    ST_LEN_L   = 4'd6,
    ST_DATA    = 4'd7,
    ST_CHK     = 4'd8
  } state_t;

  localparam int         c_chk_sum       = 0;
  localparam int         c_chk_xor       = 1;
  localparam logic [7:0] c_hdr_h_default = 8'hAA;
  localparam logic [7:0] c_hdr_l_default = 8'h44;

  // Count must be able to hold MAX_LEN itself, hence the +1.
  function automatic int len_width(input int max_len);
    return (max_len < 2) ? 1 : $clog2(max_len + 1);
  endfunction

  function automatic int addr_width(input int max_len);
    return (max_len < 2) ? 1 : $clog2(max_len);
  endfunction

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [7:0] chk_combine(input int mode, input logic [7:0] acc,
                                             input logic [7:0] b);
    return (mode == c_chk_xor) ? (acc ^ b) : (acc + b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/upload_packer_mc_if.sv
`default_nettype none
// ============================================================================
// upload_packer_mc_if : raw producer handshakes and the packed upload stream
// Revision            : 1.0
// ============================================================================
interface upload_packer_mc_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]      raw_upload_req;
  logic [NUM_CH-1:0][7:0] raw_upload_data;
  logic [NUM_CH-1:0][7:0] raw_upload_source;
  logic [NUM_CH-1:0]      raw_upload_valid;
  logic [NUM_CH-1:0]      raw_upload_ready;

  logic                   packed_upload_req;
  logic [7:0]             packed_upload_data;
  logic [7:0]             packed_upload_source;
  logic                   packed_upload_valid;
  logic                   packed_upload_ready;

  // master = the packer itself; slave = handlers plus downstream transmitter
  modport master (
    input  raw_upload_req, raw_upload_data, raw_upload_source, raw_upload_valid,
    output raw_upload_ready,
    output packed_upload_req, packed_upload_data, packed_upload_source, packed_upload_valid,
    input  packed_upload_ready
  );

  modport slave (
    output raw_upload_req, raw_upload_data, raw_upload_source, raw_upload_valid,
    input  raw_upload_ready,
    input  packed_upload_req, packed_upload_data, packed_upload_source, packed_upload_valid,
    output packed_upload_ready
  );
endinterface

`default_nettype wire

// File: rtl/upload_packer_mc_rr_arbiter.sv
`default_nettype none
// ============================================================================
// upload_rr_arbiter : combinational round-robin grant starting after last_grant
// Revision          : 1.0
// ============================================================================
module upload_rr_arbiter
  import upload_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]              req,
  input  logic [idx_width(NUM_CH)-1:0]   last_grant,
  output logic [NUM_CH-1:0]              grant,
  output logic [idx_width(NUM_CH)-1:0]   grant_idx,
  output logic                           any_grant
);
  localparam int IW = idx_width(NUM_CH);

  logic [IW-1:0] w_cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    w_cand    = '0;
    // i = NUM_CH revisits last_grant itself, so a lone requester is always served
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = IW'((int'(last_grant) + i) % NUM_CH);
      if (!any_grant && req[w_cand]) begin
        any_grant      = 1'b1;
        grant[w_cand]  = 1'b1;
        grant_idx      = w_cand;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/upload_packer_mc.sv
`default_nettype none
// ============================================================================
// upload_packer_mc : round-robin multi-channel collector and framed upload packer
// Revision         : 1.0
// ============================================================================
module upload_packer_mc
  import upload_pkg::*;
#(
  parameter int         NUM_CH         = 4,
  parameter int         MAX_LEN        = 512,
  parameter logic [7:0] FRAME_HEADER_H = c_hdr_h_default,
  parameter logic [7:0] FRAME_HEADER_L = c_hdr_l_default,
  parameter int         CHK_MODE       = c_chk_sum
) (
  input  logic                          clk,
  input  logic                          rst_n,
  upload_packer_mc_if.master            bus,
  output logic [idx_width(NUM_CH)-1:0]  active_ch,
  output logic                          busy
);
  localparam int            IW        = idx_width(NUM_CH);
  localparam int            LW        = len_width(MAX_LEN);
  localparam int            AW        = addr_width(MAX_LEN);
  localparam logic [LW-1:0] c_max_cnt = LW'(MAX_LEN);

  state_t        r_state;
  logic [IW-1:0] r_grant_idx, r_last_grant;
  logic [LW-1:0] r_count, r_rd_ptr;
  logic [7:0]    r_source, r_chk, r_out_data, r_rd_data;
  logic          r_out_valid, r_out_req;
  logic [7:0]    r_mem [MAX_LEN];

  logic [NUM_CH-1:0] w_grant;
  logic [IW-1:0]     w_grant_idx;
  logic              w_any;
  logic [7:0]        w_grant_src;
  logic              w_collect_rdy, w_wr, w_exit, w_adv, w_last, w_pop;
  logic [LW-1:0]     w_cnt_next, w_rd_next;
  logic [AW-1:0]     w_rd_addr;
  logic [15:0]       w_len16;

  upload_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req        (bus.raw_upload_req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx),
    .any_grant  (w_any)
  );

  always_comb begin
    w_grant_src = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (w_grant[i]) w_grant_src = w_grant_src | bus.raw_upload_source[i];
  end

  assign w_collect_rdy        = (r_state == ST_COLLECT) && (r_count < c_max_cnt);
  assign bus.raw_upload_ready = w_collect_rdy ? (NUM_CH'(1) << r_grant_idx) : '0;
  assign w_wr                 = w_collect_rdy && bus.raw_upload_valid[r_grant_idx];
  assign w_cnt_next           = r_count + LW'(w_wr);
  assign w_exit               = !bus.raw_upload_req[r_grant_idx] || (w_cnt_next == c_max_cnt);
  assign w_len16              = 16'(r_count);

  // r_rd_data always holds mem[r_rd_ptr]; reading one ahead on each pop keeps DATA bubble-free
  assign w_adv     = r_out_valid && bus.packed_upload_ready;
  assign w_last    = (r_rd_ptr == r_count);
  assign w_pop     = w_adv && ((r_state == ST_LEN_L) || ((r_state == ST_DATA) && !w_last));
  assign w_rd_next = w_pop ? (r_rd_ptr + LW'(1)) : r_rd_ptr;
  assign w_rd_addr = (w_rd_next < c_max_cnt) ? AW'(w_rd_next) : '0;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[AW'(r_count)] <= bus.raw_upload_data[r_grant_idx];
    r_rd_data <= r_mem[w_rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_grant_idx  <= '0;
      r_last_grant <= IW'(NUM_CH - 1);
      r_count      <= '0;
      r_rd_ptr     <= '0;
      r_source     <= '0;
      r_chk        <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_out_req    <= 1'b0;
    end else begin
      if (w_adv) r_chk <= chk_combine(CHK_MODE, r_chk, r_out_data);
      if (w_pop) r_rd_ptr <= r_rd_ptr + LW'(1);
      unique case (r_state)
        ST_IDLE: if (w_any) begin
          r_grant_idx  <= w_grant_idx;
          r_last_grant <= w_grant_idx;
          r_source     <= w_grant_src;
          r_count      <= '0;
          r_state      <= ST_COLLECT;
        end
        ST_COLLECT: begin
          r_count <= w_cnt_next;
          if (w_exit) begin
            if (w_cnt_next == '0) begin
              r_state     <= ST_IDLE;
              r_grant_idx <= '0;
            end else begin
              r_state     <= ST_HDR1;
              r_out_valid <= 1'b1;
              r_out_req   <= 1'b1;
              r_out_data  <= FRAME_HEADER_H;
              r_chk       <= '0;
              r_rd_ptr    <= '0;
            end
          end
        end
        ST_HDR1:  if (w_adv) begin r_out_data <= FRAME_HEADER_L; r_state <= ST_HDR2;  end
        ST_HDR2:  if (w_adv) begin r_out_data <= r_source;       r_state <= ST_SRC;   end
        ST_SRC:   if (w_adv) begin r_out_data <= w_len16[15:8];  r_state <= ST_LEN_H; end
        ST_LEN_H: if (w_adv) begin r_out_data <= w_len16[7:0];   r_state <= ST_LEN_L; end
        ST_LEN_L: if (w_adv) begin r_out_data <= r_rd_data;      r_state <= ST_DATA;  end
        ST_DATA: if (w_adv) begin
          if (w_last) begin
            r_out_data <= chk_combine(CHK_MODE, r_chk, r_out_data);
            r_state    <= ST_CHK;
          end else begin
            r_out_data <= r_rd_data;
          end
        end
        ST_CHK: if (w_adv) begin
          r_out_valid <= 1'b0;
          r_out_req   <= 1'b0;
          r_out_data  <= '0;
          r_grant_idx <= '0;
          r_state     <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.packed_upload_req    = r_out_req;
  assign bus.packed_upload_data   = r_out_data;
  assign bus.packed_upload_source = r_source;
  assign bus.packed_upload_valid  = r_out_valid;
  assign active_ch                = r_grant_idx;
  assign busy                     = (r_state != ST_IDLE);

endmodule

`default_nettype wire
